apb_requester_bridge: RTL and testbench

//  Single-outstanding bridge from a valid/ready command port onto the requester side of an APB bus (IHI 0024D).

---
 rtl/apb_requester_bridge_if.sv | 35 +++
 rtl/apb_requester_bridge.sv | 185 ++++++++++++++++++
 tb/tb_apb_requester_bridge.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_requester_bridge_if.sv
// APB bus bundle (IHI 0024D signal set) with requester and completer views.
// Widths must agree with the bridge parameters that drive it.
interface APB #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int USER_WIDTH = 1
);
    logic                    pclk;
    logic                    preset_n;
    logic [ADDR_WIDTH-1:0]   paddr;
    logic                    psel;
    logic                    penable;
    logic                    pwrite;
    logic [DATA_WIDTH-1:0]   pwdata;
    logic [DATA_WIDTH/8-1:0] pstrb;
    logic [2:0]              pprot;
    logic                    pwakeup;
    logic [USER_WIDTH-1:0]   pauser;
    logic [USER_WIDTH-1:0]   pwuser;
    logic                    pready;
    logic [DATA_WIDTH-1:0]   prdata;
    logic                    pslverr;

    modport requester (
        output pclk, preset_n, paddr, psel, penable, pwrite, pwdata, pstrb, pprot,
               pwakeup, pauser, pwuser,
        input  pready, prdata, pslverr
    );

    modport completer (
        input  pclk, preset_n, paddr, psel, penable, pwrite, pwdata, pstrb, pprot,
               pwakeup, pauser, pwuser,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/apb_requester_bridge.sv
// Single-outstanding valid/ready command port to APB requester bridge, one response per command.
// Optional ACCESS-phase timeout is enabled by defining APB_BRIDGE_TIMEOUT_EN.
module apb_requester_bridge #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int TIMEOUT    = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
    input  logic [2:0]              cmd_prot,
    output logic                    rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    rsp_timeout,
    output logic [1:0]              dbg_state,
    APB.requester                   apb
);
    localparam int STRB_W = DATA_WIDTH / 8;

    // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
    // cmd_valid may be held across cycles, and the response is a one-cycle rsp_valid
    // pulse with no backpressure, fields holding until the next response.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t                  state, state_next;
    logic                    psel_q, psel_next;
    logic                    penable_q, penable_next;
    logic                    pwrite_q, pwrite_next;
    logic [ADDR_WIDTH-1:0]   paddr_q, paddr_next;
    logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_next;
    logic [STRB_W-1:0]       pstrb_q, pstrb_next;
    logic [2:0]              pprot_q, pprot_next;
    logic                    rsp_valid_q, rsp_valid_next;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_next;
    logic                    rsp_err_q, rsp_err_next;
    logic                    rsp_timeout_q, rsp_timeout_next;

`ifdef APB_BRIDGE_TIMEOUT_EN
    localparam int CNT_RAW = $clog2(TIMEOUT + 1);
    localparam int CNT_W   = (CNT_RAW < 8) ? 8 : ((CNT_RAW > 32) ? 32 : CNT_RAW);

    logic [CNT_W-1:0] cnt_q, cnt_next;
    logic             expire;

    // Expiry fires in the TIMEOUT-th ACCESS cycle still lacking pready.
    assign expire = ((cnt_q + CNT_W'(1)) == CNT_W'(TIMEOUT));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT != 0);
`endif

    assign cmd_ready   = (state == IDLE) && !rst;
    assign dbg_state   = state;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;

    assign apb.pclk     = clk;
    assign apb.preset_n = ~rst;
    assign apb.psel     = psel_q;
    assign apb.penable  = penable_q;
    assign apb.pwrite   = pwrite_q;
    assign apb.paddr    = paddr_q;
    assign apb.pwdata   = pwdata_q;
    assign apb.pstrb    = pstrb_q;
    assign apb.pprot    = pprot_q;
    assign apb.pwakeup  = psel_q || cmd_valid;
    assign apb.pauser   = '0;
    assign apb.pwuser   = '0;

    always_comb begin
        state_next       = state;
        psel_next        = psel_q;
        penable_next     = penable_q;
        pwrite_next      = pwrite_q;
        paddr_next       = paddr_q;
        pwdata_next      = pwdata_q;
        pstrb_next       = pstrb_q;
        pprot_next       = pprot_q;
        rsp_valid_next   = 1'b0;
        rsp_rdata_next   = rsp_rdata_q;
        rsp_err_next     = rsp_err_q;
        rsp_timeout_next = rsp_timeout_q;
`ifdef APB_BRIDGE_TIMEOUT_EN
        cnt_next         = cnt_q;
`endif
        unique case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    paddr_next   = cmd_addr;
                    pwdata_next  = cmd_wdata;
                    pprot_next   = cmd_prot;
                    pwrite_next  = cmd_write;
                    pstrb_next   = cmd_write ? cmd_wstrb : '0;
                    psel_next    = 1'b1;
                    penable_next = 1'b0;
                    state_next   = SETUP;
                end
            end
            SETUP: begin
                penable_next = 1'b1;
                state_next   = ACCESS;
`ifdef APB_BRIDGE_TIMEOUT_EN
                cnt_next     = '0;
`endif
            end
            ACCESS: begin
                if (apb.pready) begin
                    psel_next        = 1'b0;
                    penable_next     = 1'b0;
                    state_next       = IDLE;
                    rsp_valid_next   = 1'b1;
                    rsp_err_next     = apb.pslverr;
                    rsp_timeout_next = 1'b0;
                    rsp_rdata_next   = (pwrite_q || apb.pslverr) ? '0 : apb.prdata;
                end
`ifdef APB_BRIDGE_TIMEOUT_EN
                else if (expire) begin
                    psel_next        = 1'b0;
                    penable_next     = 1'b0;
                    state_next       = IDLE;
                    rsp_valid_next   = 1'b1;
                    rsp_err_next     = 1'b1;
                    rsp_timeout_next = 1'b1;
                    rsp_rdata_next   = '0;
                end else begin
                    cnt_next = cnt_q + CNT_W'(1);
                end
`endif
            end
            default: begin
                psel_next    = 1'b0;
                penable_next = 1'b0;
                state_next   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            pstrb_q       <= '0;
            pprot_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
`ifdef APB_BRIDGE_TIMEOUT_EN
            cnt_q         <= '0;
`endif
        end else begin
            state         <= state_next;
            psel_q        <= psel_next;
            penable_q     <= penable_next;
            pwrite_q      <= pwrite_next;
            paddr_q       <= paddr_next;
            pwdata_q      <= pwdata_next;
            pstrb_q       <= pstrb_next;
            pprot_q       <= pprot_next;
            rsp_valid_q   <= rsp_valid_next;
            rsp_rdata_q   <= rsp_rdata_next;
            rsp_err_q     <= rsp_err_next;
            rsp_timeout_q <= rsp_timeout_next;
`ifdef APB_BRIDGE_TIMEOUT_EN
            cnt_q         <= cnt_next;
`endif
        end
    end
endmodule

// File: tb/tb_apb_requester_bridge.sv
// Directed bench for apb_requester_bridge: vector table of single transfers plus
// hand-written back-to-back, timeout/no-timeout and mid-transfer reset sequences.
module tb_apb_requester_bridge;
    localparam int DW = 32;
    localparam int AW = 16;
`ifdef APB_BRIDGE_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 255;
`endif

    logic          clk;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [3:0]    cmd_wstrb;
    logic [2:0]    cmd_prot;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;
    logic [1:0]    dbg_state;

    APB #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) apb_bus ();

    apb_requester_bridge #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata),
        .cmd_wstrb(cmd_wstrb),
        .cmd_prot(cmd_prot),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout),
        .dbg_state(dbg_state),
        .apb(apb_bus.requester)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [DW-1:0] exp_q[$];

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [3:0]    wstrb;
        logic [2:0]    prot;
        int            wait_cycles;
        logic          slverr;
        logic [DW-1:0] prdata;
        logic [3:0]    exp_strb;
        logic [DW-1:0] exp_rdata;
        logic          exp_err;
    } vec_t;

    vec_t vecs[5];

    // driver: one full transfer, checked cycle by cycle (all sampling at negedge)
    task automatic run_txn(input vec_t v);
        logic [DW-1:0] exp_d;
        @(negedge clk);
        check("idle_ready", cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_write = v.write;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        cmd_wstrb = v.wstrb;
        cmd_prot  = v.prot;
        exp_q.push_back(v.exp_rdata);
        @(negedge clk);  // N+1: SETUP
        cmd_valid = 1'b0;
        cmd_addr  = ~v.addr;
        cmd_wdata = ~v.wdata;
        check("setup_psel", apb_bus.psel, 1'b1);
        check("setup_penable", apb_bus.penable, 1'b0);
        check("setup_ready", cmd_ready, 1'b0);
        check("setup_pwrite", apb_bus.pwrite, v.write);
        check("setup_pstrb", apb_bus.pstrb, v.exp_strb);
        check("setup_paddr", apb_bus.paddr, v.addr);
        if (v.write) check("setup_pwdata", apb_bus.pwdata, v.wdata);
        @(negedge clk);  // N+2: first ACCESS cycle
        for (int w = 0; w <= v.wait_cycles; w++) begin
            check("access_psel", apb_bus.psel, 1'b1);
            check("access_penable", apb_bus.penable, 1'b1);
            check("access_paddr", apb_bus.paddr, v.addr);
            check("access_pprot", apb_bus.pprot, v.prot);
            check("access_norsp", rsp_valid, 1'b0);
            if (w == v.wait_cycles) begin
                apb_bus.pready  = 1'b1;
                apb_bus.pslverr = v.slverr;
                apb_bus.prdata  = v.prdata;
            end else begin
                apb_bus.pslverr = 1'b1;  // must be ignored while pready is low
            end
            @(negedge clk);
        end
        apb_bus.pready  = 1'b0;
        apb_bus.pslverr = 1'b0;
        apb_bus.prdata  = 32'h0;
        check("rsp_valid", rsp_valid, 1'b1);
        check("rsp_err", rsp_err, v.exp_err);
        check("rsp_timeout", rsp_timeout, 1'b0);
        check("rsp_psel_drop", apb_bus.psel, 1'b0);
        check("rsp_ready", cmd_ready, 1'b1);
        // scoreboard
        if (exp_q.size() == 0) begin
            check("sb_nonempty", 32'd0, 32'd1);
        end else begin
            exp_d = exp_q.pop_front();
            check("rsp_rdata", rsp_rdata, exp_d);
        end
        @(negedge clk);
        check("rsp_pulse", rsp_valid, 1'b0);
    endtask

    initial begin
        int n_acc;
        int n_rsp;
        int last;
        int seen;

        vecs[0] = '{1'b1, 16'h0040, 32'h0000_1234, 4'hF, 3'd0, 0, 1'b0, 32'hAAAA_5555, 4'hF, 32'h0, 1'b0};
        vecs[1] = '{1'b0, 16'h0010, 32'h1111_1111, 4'hF, 3'd2, 3, 1'b0, 32'hDEAD_BEEF, 4'h0, 32'hDEAD_BEEF, 1'b0};
        vecs[2] = '{1'b0, 16'h0020, 32'h0,         4'h0, 3'd0, 1, 1'b1, 32'h1234_5678, 4'h0, 32'h0, 1'b1};
        vecs[3] = '{1'b1, 16'hFFFC, 32'hCAFE_F00D, 4'h5, 3'd7, 2, 1'b1, 32'h5555_AAAA, 4'h5, 32'h0, 1'b1};
        vecs[4] = '{1'b0, 16'h8001, 32'h0,         4'hA, 3'd1, 0, 1'b0, 32'h0000_00FF, 4'h0, 32'h0000_00FF, 1'b0};

        rst             = 1'b1;
        cmd_valid       = 1'b0;
        cmd_write       = 1'b0;
        cmd_addr        = '0;
        cmd_wdata       = '0;
        cmd_wstrb       = '0;
        cmd_prot        = '0;
        apb_bus.pready  = 1'b0;
        apb_bus.pslverr = 1'b0;
        apb_bus.prdata  = '0;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_ready", cmd_ready, 1'b0);
        check("rst_psel", apb_bus.psel, 1'b0);
        check("rst_penable", apb_bus.penable, 1'b0);
        check("rst_paddr", apb_bus.paddr, 16'h0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_preset_n", apb_bus.preset_n, 1'b0);
        check("rst_state", dbg_state, 2'd0);
        check("rst_pwakeup", apb_bus.pwakeup, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", cmd_ready, 1'b1);
        check("post_rst_preset_n", apb_bus.preset_n, 1'b1);
        cmd_valid = 1'b1;
        #1;
        check("pwakeup_cmd", apb_bus.pwakeup, 1'b1);
        cmd_valid = 1'b0;

        // vector table
        for (int i = 0; i < 5; i++) run_txn(vecs[i]);

        // back-to-back writes with cmd_valid held high and pready tied 1
        cmd_valid      = 1'b1;
        cmd_write      = 1'b1;
        cmd_addr       = 16'h0100;
        cmd_wdata      = 32'h0BAD_F00D;
        cmd_wstrb      = 4'h3;
        cmd_prot       = 3'd0;
        apb_bus.pready = 1'b1;
        n_acc = 0;
        n_rsp = 0;
        last  = -10;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (rsp_valid) n_rsp++;
            if (c == last + 1) begin
                check("b2b_setup_psel", apb_bus.psel, 1'b1);
                check("b2b_setup_penable", apb_bus.penable, 1'b0);
            end
            if (c == last + 2) check("b2b_access_penable", apb_bus.penable, 1'b1);
            if (cmd_valid && cmd_ready) begin
                if (n_acc > 0) check("b2b_spacing", c - last, 3);
                last = c;
                n_acc++;
            end
            if (c == 11) cmd_valid = 1'b0;
        end
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid) n_rsp++;
        end
        apb_bus.pready = 1'b0;
        check("b2b_accepts", n_acc, 4);
        check("b2b_responses", n_rsp, 4);
        check("b2b_rsp_err", rsp_err, 1'b0);

        // stuck pready: timeout abort or indefinite wait
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 16'h0200;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);  // first ACCESS cycle
`ifdef APB_BRIDGE_TIMEOUT_EN
        seen = 0;
        for (int c = 1; c <= 40; c++) begin
            if (rsp_valid && seen == 0) begin
                seen = c;
                check("tmo_err", rsp_err, 1'b1);
                check("tmo_flag", rsp_timeout, 1'b1);
                check("tmo_rdata", rsp_rdata, 32'h0);
                check("tmo_psel", apb_bus.psel, 1'b0);
                check("tmo_penable", apb_bus.penable, 1'b0);
            end
            @(negedge clk);
        end
        // 8 ACCESS cycles (1..8), response visible in cycle 9
        check("tmo_latency", seen, 9);
`else
        seen = 0;
        for (int c = 0; c < 1000; c++) begin
            if (rsp_valid) seen++;
            @(negedge clk);
        end
        check("notmo_no_rsp", seen, 0);
        check("notmo_state", dbg_state, 2'd2);
        check("notmo_psel", apb_bus.psel, 1'b1);
        check("notmo_penable", apb_bus.penable, 1'b1);
        check("notmo_flag", rsp_timeout, 1'b0);
        // recover the stalled transfer via reset
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
`endif

        // reset asserted during ACCESS
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 16'h0300;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mrst_in_access", apb_bus.penable, 1'b1);
        rst = 1'b1;
        apb_bus.pready = 1'b1;
        @(negedge clk);
        check("mrst_psel", apb_bus.psel, 1'b0);
        check("mrst_penable", apb_bus.penable, 1'b0);
        check("mrst_no_rsp", rsp_valid, 1'b0);
        check("mrst_ready_low", cmd_ready, 1'b0);
        rst = 1'b0;
        apb_bus.pready = 1'b0;
        @(negedge clk);
        check("mrst_ready", cmd_ready, 1'b1);
        check("mrst_no_rsp_after", rsp_valid, 1'b0);
        check("mrst_state", dbg_state, 2'd0);

        // final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
